// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver and the planned transmitter.
//   PARITY_NONE / PARITY_ODD / PARITY_EVEN : values for the PARITY parameter
//   rx_state_t                             : receiver FSM states
//   majority3()                            : 2-of-3 vote used to de-noise bit samples
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Sample-tick generator shared by the serial receiver and transmitter.
// Produces a one-clock tick every max(divisor,1) clocks. The divisor is captured
// when restart is pulsed, so later changes on the port do not disturb a frame
// already in progress. restart also realigns the tick phase.
// Ports:
//   clk      in   system clock
//   resetN   in   asynchronous active-low reset
//   divisor  in   clocks per tick (0 behaves as 1)
//   restart  in   re-phase the counter and capture divisor
//   tick     out  one-clock pulse per sample period
module serial_baud_tick #(
    parameter int DIVISOR_BITS = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [DIVISOR_BITS-1:0] divisor,
    input  logic                    restart,
    output logic                    tick
);

    logic [DIVISOR_BITS-1:0] div_q;
    logic [DIVISOR_BITS-1:0] div_eff;
    logic [DIVISOR_BITS-1:0] cnt;

    assign div_eff = (divisor == '0) ? DIVISOR_BITS'(1) : divisor;

    // The tick is suppressed in the restart cycle so the first tick of a new
    // frame lands a full period after the restart.
    assign tick = !restart && (cnt == div_q - DIVISOR_BITS'(1));

    // Counter runs 0..div_q-1; restart zeroes it and captures the divisor.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q <= DIVISOR_BITS'(1);
            cnt   <= '0;
        end else if (restart) begin
            div_q <= div_eff;
            cnt   <= '0;
        end else if (tick) begin
            cnt   <= '0;
        end else begin
            cnt   <= cnt + DIVISOR_BITS'(1);
        end
    end

endmodule

// File: rtl/serial_rx_oversampled.sv
// Parametrised oversampling UART receiver with a valid/ack holding register.
// Each bit is sampled OVERSAMPLE times; the value is the 2-of-3 majority of the
// three ticks around mid-bit. Reports parity, framing, overrun and break.
// Ports:
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   serialIn     in   raw RX line, idle high
//   divisor      in   clocks per sample tick (0 behaves as 1)
//   data         out  last received word
//   dataValid    out  word held, awaiting dataAck
//   dataAck      in   consumer takes the held word
//   parityError  out  parity of the held word was wrong
//   framingError out  a stop bit of the held word sampled 0
//   overrun      out  a held word was overwritten; cleared by dataAck
//   breakDetect  out  one-clock pulse on an all-zero frame with stop bit 0
module serial_rx_oversampled
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int DIVISOR_BITS = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    serialIn,
    input  logic [DIVISOR_BITS-1:0] divisor,
    output logic [DATA_BITS-1:0]    data,
    output logic                    dataValid,
    input  logic                    dataAck,
    output logic                    parityError,
    output logic                    framingError,
    output logic                    overrun,
    output logic                    breakDetect
);

    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);
    localparam int HALF     = OVERSAMPLE / 2;

    logic                 sync_1;
    logic                 rx;
    logic                 rx_prev;
    logic                 fall;

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 restart;
    logic                 complete;
    logic                 tick;
    logic                 vote_tick;
    logic                 bit_val;

    logic [SAMPLE_W-1:0]  samp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 vote_a;
    logic                 vote_b;
    logic                 par_err_q;
    logic                 frame_err_q;
    logic                 frame_err_next;
    logic                 is_break;
    logic                 load;
    logic                 data_last;
    logic                 stop_last;

    serial_baud_tick #(
        .DIVISOR_BITS(DIVISOR_BITS)
    ) u_tick (
        .clk     (clk),
        .resetN  (resetN),
        .divisor (divisor),
        .restart (restart),
        .tick    (tick)
    );

    // Two-flop synchroniser plus one delayed copy for edge detection. All
    // three reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_1  <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= serialIn;
            rx      <= sync_1;
            rx_prev <= rx;
        end
    end

    // A start needs a genuine 1->0 edge, so after a break the receiver stays
    // disarmed until the line has been high again.
    assign fall      = rx_prev & ~rx;
    assign vote_tick = tick && (samp_cnt == SAMPLE_W'(HALF + 1));
    assign bit_val   = majority3(vote_a, vote_b, rx);
    assign data_last = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == BIT_W'(STOP_BITS - 1));

    assign frame_err_next = frame_err_q | ~bit_val;
    assign is_break       = (shift == '0) && frame_err_next;
    assign load           = complete && !is_break;

    // Next-state logic; every transition out of a bit happens on its vote tick.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        complete   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    restart    = 1'b1;
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (vote_tick) begin
                    state_next = bit_val ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (vote_tick && data_last) begin
                    state_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (vote_tick) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (vote_tick && stop_last) begin
                    complete   = 1'b1;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Datapath, counters and the holding register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= RX_IDLE;
            samp_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            vote_a       <= 1'b0;
            vote_b       <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            data         <= '0;
            dataValid    <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
            breakDetect  <= 1'b0;
        end else begin
            state <= state_next;

            // Sample counter is free-running modulo OVERSAMPLE inside a frame.
            if (restart || state_next == RX_IDLE) begin
                samp_cnt <= '0;
            end else if (tick) begin
                samp_cnt <= (samp_cnt == SAMPLE_W'(OVERSAMPLE - 1)) ? '0
                            : samp_cnt + SAMPLE_W'(1);
            end

            if (tick && samp_cnt == SAMPLE_W'(HALF - 1)) begin
                vote_a <= rx;
            end
            if (tick && samp_cnt == SAMPLE_W'(HALF)) begin
                vote_b <= rx;
            end

            if (restart) begin
                bit_cnt     <= '0;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end else if (vote_tick) begin
                case (state)
                    RX_DATA: begin
                        shift   <= {bit_val, shift[DATA_BITS-1:1]};
                        bit_cnt <= data_last ? '0 : bit_cnt + BIT_W'(1);
                    end
                    RX_PARITY: begin
                        par_err_q <= ((^shift) ^ bit_val) != (PARITY == PARITY_ODD);
                    end
                    RX_STOP: begin
                        frame_err_q <= frame_err_next;
                        bit_cnt     <= stop_last ? '0 : bit_cnt + BIT_W'(1);
                    end
                    default: ;
                endcase
            end

            breakDetect <= complete && is_break;

            // A completing word wins over an ack; an ack in the same cycle only
            // prevents the overrun flag from being raised.
            if (load) begin
                data         <= shift;
                parityError  <= par_err_q;
                framingError <= frame_err_next;
                dataValid    <= 1'b1;
                overrun      <= dataAck ? 1'b0 : (overrun | dataValid);
            end else if (dataAck && dataValid) begin
                dataValid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_oversampled.sv
module tb_serial_rx_oversampled;

    logic        clk = 1'b0;
    logic        resetN;
    logic        serialIn;
    logic        serialIn2;
    logic [15:0] divisor;
    logic        dataAck;
    logic        dataAck2;

    logic [7:0]  data;
    logic        dataValid, parityError, framingError, overrun, breakDetect;
    logic [7:0]  data2;
    logic        dataValid2, parityError2, framingError2, overrun2, breakDetect2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int startCyc = 0;
    int riseCyc = -1;
    int breakCnt = 0;
    logic prevValid = 1'b0;

    always #5 clk = ~clk;

    serial_rx_oversampled u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .serialIn     (serialIn),
        .divisor      (divisor),
        .data         (data),
        .dataValid    (dataValid),
        .dataAck      (dataAck),
        .parityError  (parityError),
        .framingError (framingError),
        .overrun      (overrun),
        .breakDetect  (breakDetect)
    );

    serial_rx_oversampled #(.PARITY(2)) u_par (
        .clk          (clk),
        .resetN       (resetN),
        .serialIn     (serialIn2),
        .divisor      (divisor),
        .data         (data2),
        .dataValid    (dataValid2),
        .dataAck      (dataAck2),
        .parityError  (parityError2),
        .framingError (framingError2),
        .overrun      (overrun2),
        .breakDetect  (breakDetect2)
    );

    // Clock-edge counter used to measure frame latency.
    always @(posedge clk) cyc++;

    // Records the cycle on which dataValid rises and counts break pulses.
    always @(negedge clk) begin
        if (dataValid && !prevValid) riseCyc = cyc;
        prevValid = dataValid;
        if (breakDetect) breakCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a frame LSB first; each bit lasts 16*div clocks. An optional
    // one-clock inverted spike is placed in the middle of bit spikeBit.
    task automatic applyStimulus(input logic [15:0] bits, input int nbits, input int div,
                                 input int spikeBit, input bit useSecond);
        logic v;
        @(posedge clk); #1;
        startCyc = cyc;
        riseCyc  = -1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 16 * div; c++) begin
                v = bits[b];
                if (b == spikeBit && c == 9 * div) v = ~v;
                if (useSecond) serialIn2 = v;
                else serialIn = v;
                @(posedge clk); #1;
            end
        end
        serialIn  = 1'b1;
        serialIn2 = 1'b1;
    endtask

    task automatic ackWord(input bit useSecond);
        @(posedge clk); #1;
        if (useSecond) dataAck2 = 1'b1;
        else dataAck = 1'b1;
        @(posedge clk); #1;
        dataAck  = 1'b0;
        dataAck2 = 1'b0;
    endtask

    initial begin
        resetN    = 1'b1;
        serialIn  = 1'b1;
        serialIn2 = 1'b1;
        divisor   = 16'd1;
        dataAck   = 1'b0;
        dataAck2  = 1'b0;
        #2 resetN = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(dataValid), 32'd0);
        checkOutput("rst_data", 32'(data), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_break", 32'(breakDetect), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (5) @(posedge clk);

        $display("[TB] 8N1 frame 0xA5");
        applyStimulus({1'b1, 8'hA5, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t1_latency", 32'(riseCyc - startCyc), 32'd157);
        checkOutput("t1_valid", 32'(dataValid), 32'd1);
        checkOutput("t1_data", 32'(data), 32'hA5);
        checkOutput("t1_perr", 32'(parityError), 32'd0);
        checkOutput("t1_ferr", 32'(framingError), 32'd0);
        ackWord(1'b0);
        checkOutput("t1_ack_valid", 32'(dataValid), 32'd0);

        $display("[TB] even parity frames 0x07");
        applyStimulus({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1, -1, 1'b1);
        checkOutput("t2_valid", 32'(dataValid2), 32'd1);
        checkOutput("t2_data", 32'(data2), 32'h07);
        checkOutput("t2_perr_bad", 32'(parityError2), 32'd1);
        ackWord(1'b1);
        applyStimulus({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1, -1, 1'b1);
        checkOutput("t2b_valid", 32'(dataValid2), 32'd1);
        checkOutput("t2b_perr_ok", 32'(parityError2), 32'd0);
        checkOutput("t2b_ferr", 32'(framingError2), 32'd0);
        ackWord(1'b1);

        $display("[TB] glitch and spike rejection");
        @(posedge clk); #1 serialIn = 1'b0;
        repeat (6) @(posedge clk);
        #1 serialIn = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("t3_glitch_valid", 32'(dataValid), 32'd0);
        applyStimulus({1'b1, 8'h0F, 1'b0}, 10, 1, 3, 1'b0);
        checkOutput("t3_spike_data", 32'(data), 32'h0F);
        checkOutput("t3_spike_latency", 32'(riseCyc - startCyc), 32'd157);
        ackWord(1'b0);

        $display("[TB] overrun");
        applyStimulus({1'b1, 8'h11, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t4_first_overrun", 32'(overrun), 32'd0);
        applyStimulus({1'b1, 8'h22, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t4_data", 32'(data), 32'h22);
        checkOutput("t4_overrun", 32'(overrun), 32'd1);
        checkOutput("t4_valid", 32'(dataValid), 32'd1);
        ackWord(1'b0);
        checkOutput("t4_ack_valid", 32'(dataValid), 32'd0);
        checkOutput("t4_ack_overrun", 32'(overrun), 32'd0);

        $display("[TB] break");
        breakCnt = 0;
        @(posedge clk); #1 serialIn = 1'b0;
        repeat (192) @(posedge clk);
        #1 serialIn = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("t5_break_count", 32'(breakCnt), 32'd1);
        checkOutput("t5_valid", 32'(dataValid), 32'd0);
        applyStimulus({1'b1, 8'h3C, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t5_data", 32'(data), 32'h3C);
        checkOutput("t5_ferr", 32'(framingError), 32'd0);
        checkOutput("t5_break_after", 32'(breakCnt), 32'd1);

        $display("[TB] reset mid-frame");
        @(posedge clk); #1 serialIn = 1'b0;
        repeat (16) @(posedge clk);
        #1 serialIn = 1'b1;
        repeat (8) @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(dataValid), 32'd0);
        checkOutput("t6_rst_data", 32'(data), 32'd0);
        checkOutput("t6_rst_ferr", 32'(framingError), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("t6_idle_valid", 32'(dataValid), 32'd0);
        applyStimulus({1'b1, 8'h5A, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t6_data", 32'(data), 32'h5A);
        checkOutput("t6_latency", 32'(riseCyc - startCyc), 32'd157);
        ackWord(1'b0);

        $display("[TB] divisor latching and zero divisor");
        divisor = 16'd3;
        fork
            applyStimulus({1'b1, 8'h96, 1'b0}, 10, 3, -1, 1'b0);
            begin
                repeat (60) @(posedge clk);
                #1 divisor = 16'd1;
            end
        join
        checkOutput("t7_data", 32'(data), 32'h96);
        checkOutput("t7_latency", 32'(riseCyc - startCyc), 32'd465);
        ackWord(1'b0);
        divisor = 16'd0;
        applyStimulus({1'b1, 8'hC3, 1'b0}, 10, 1, -1, 1'b0);
        checkOutput("t7_div0_data", 32'(data), 32'hC3);
        checkOutput("t7_div0_latency", 32'(riseCyc - startCyc), 32'd157);
        ackWord(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
